// File: rtl/can_pkg.sv
`default_nettype none
// ============================================================================
// Module      : can_pkg
// Description : Shared types for the CAN transmit scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package can_pkg;

    localparam int CAN_MSG_W = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        REQ  = 2'd2,
        WAIT = 2'd3
    } tx_sched_state_t;

    typedef logic [CAN_MSG_W-1:0] can_msg_t;

endpackage
`default_nettype wire

// File: rtl/can_tx_retry_ctr.sv
`default_nettype none
// ============================================================================
// Module      : can_tx_retry_ctr
// Description : Per-message error retry counter with clear, saturating
//               increment and a retry-limit-hit flag.
// Revision    : 1.0 - initial release
// ============================================================================
module can_tx_retry_ctr #(
    parameter int MAX_RETRY = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_clr,
    input  logic       i_inc,
    output logic [3:0] o_cnt,
    output logic       o_limit_hit
);

    logic [3:0]  r_cnt;
    logic [31:0] w_cnt_p1;

    assign w_cnt_p1 = {28'd0, r_cnt} + 32'd1;

    // Limit is reached when the error now being reported would be the
    // MAX_RETRY-th one; a limit of zero disables dropping entirely.
    assign o_limit_hit = (MAX_RETRY != 0) && (w_cnt_p1 >= 32'(MAX_RETRY));
    assign o_cnt       = r_cnt;

    // Counter register: clear wins over increment, increment saturates at 15.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= 4'd0;
        end else if (i_clr) begin
            r_cnt <= 4'd0;
        end else if (i_inc && (r_cnt != 4'hF)) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/can_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : can_tx_scheduler
// Description : Arbitrates the CAN TX engine between the high-priority buffer
//               and the TX FIFO, holds the selected message, and handles
//               retry, drop and abort on bus-off / core disable.
// Revision    : 1.0 - initial release
// ============================================================================
module can_tx_scheduler
    import can_pkg::*;
#(
    parameter int MAX_RETRY = 8,
    parameter int MSG_W     = CAN_MSG_W
) (
    input  logic             i_sys_clk,
    input  logic             i_reset_n,
    input  logic             i_cen,
    input  logic             i_bsoff,
    input  logic             i_hpb_full,
    input  logic [MSG_W-1:0] i_hpb_data,
    output logic             o_hpb_r_en,
    input  logic             i_tx_empty,
    input  logic [MSG_W-1:0] i_tx_fifo_data,
    output logic             o_tx_r_en,
    output logic [MSG_W-1:0] o_msg_data,
    output logic             o_msg_valid,
    input  logic             i_msg_ready,
    input  logic             i_txok,
    input  logic             i_arblst,
    input  logic             i_error,
    output logic             o_src_hpb,
    output logic [3:0]       o_retry_cnt,
    output logic             o_tx_done,
    output logic             o_drop,
    output logic             o_abort,
    output logic             o_busy
);

    tx_sched_state_t r_state, w_state_nxt;

    logic             r_sel_hpb;     // source chosen when leaving IDLE
    logic             w_sel_nxt;
    logic [MSG_W-1:0] r_msg_data;
    logic             r_src_hpb;
    logic             r_tx_done, r_drop, r_abort;
    logic             w_tx_done_nxt, w_drop_nxt, w_abort_nxt;
    logic             w_msg_valid;
    logic             w_ctr_clr, w_ctr_inc, w_limit_hit;
    logic             w_run;

    assign w_run = i_cen & ~i_bsoff;

    // Pops depend only on registered state so no input reaches a pop strobe.
    assign o_hpb_r_en  = (r_state == LOAD) &  r_sel_hpb;
    assign o_tx_r_en   = (r_state == LOAD) & ~r_sel_hpb;
    assign w_ctr_clr   = (r_state == LOAD);

    assign o_msg_data  = r_msg_data;
    assign o_msg_valid = w_msg_valid;
    assign o_src_hpb   = r_src_hpb;
    assign o_tx_done   = r_tx_done;
    assign o_drop      = r_drop;
    assign o_abort     = r_abort;
    assign o_busy      = (r_state != IDLE);

    can_tx_retry_ctr #(
        .MAX_RETRY (MAX_RETRY)
    ) u_retry_ctr (
        .i_clk       (i_sys_clk),
        .i_rst_n     (i_reset_n),
        .i_clr       (w_ctr_clr),
        .i_inc       (w_ctr_inc),
        .o_cnt       (o_retry_cnt),
        .o_limit_hit (w_limit_hit)
    );

    // State, source select and registered outcome pulses.
    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= IDLE;
            r_sel_hpb <= 1'b0;
            r_tx_done <= 1'b0;
            r_drop    <= 1'b0;
            r_abort   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_sel_hpb <= w_sel_nxt;
            r_tx_done <= w_tx_done_nxt;
            r_drop    <= w_drop_nxt;
            r_abort   <= w_abort_nxt;
        end
    end

    // Holding register: captured at the end of LOAD, held through IDLE.
    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_msg_data <= '0;
            r_src_hpb  <= 1'b0;
        end else if (r_state == LOAD) begin
            r_msg_data <= r_sel_hpb ? i_hpb_data : i_tx_fifo_data;
            r_src_hpb  <= r_sel_hpb;
        end
    end

    // Next-state and outcome decode; abort takes precedence in every busy state.
    always_comb begin
        w_state_nxt   = r_state;
        w_sel_nxt     = r_sel_hpb;
        w_msg_valid   = 1'b0;
        w_tx_done_nxt = 1'b0;
        w_drop_nxt    = 1'b0;
        w_abort_nxt   = 1'b0;
        w_ctr_inc     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_run) begin
                    if (i_hpb_full) begin
                        w_state_nxt = LOAD;
                        w_sel_nxt   = 1'b1;
                    end else if (!i_tx_empty) begin
                        w_state_nxt = LOAD;
                        w_sel_nxt   = 1'b0;
                    end
                end
            end
            LOAD: begin
                if (!w_run) begin
                    w_state_nxt = IDLE;
                    w_abort_nxt = 1'b1;
                end else begin
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                if (!w_run) begin
                    w_state_nxt = IDLE;
                    w_abort_nxt = 1'b1;
                end else begin
                    w_msg_valid = 1'b1;
                    if (i_msg_ready) begin
                        w_state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!w_run) begin
                    w_state_nxt = IDLE;
                    w_abort_nxt = 1'b1;
                end else if (i_txok) begin
                    w_state_nxt   = IDLE;
                    w_tx_done_nxt = 1'b1;
                end else if (i_error) begin
                    if (w_limit_hit) begin
                        w_state_nxt = IDLE;
                        w_drop_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = REQ;
                        w_ctr_inc   = 1'b1;
                    end
                end else if (i_arblst) begin
                    w_state_nxt = REQ;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: doc/can_tx_scheduler.md
Name: can_tx_scheduler

Overview:
- Shares the CAN transmit engine between two message sources: the high-priority buffer (HPB) and the TX FIFO, both fed by the configuration register file.
- Selects the next message with fixed priority (HPB first), pops it into a holding register, and presents it to the transmitter.
- Tracks the outcome of each attempt: success, arbitration loss or error.
- Retries as needed, drops the message after a retry limit, and aborts on bus-off or core disable.

Parameters:
- MAX_RETRY, 8, error-retry limit per message; 0 = unlimited.
- MSG_W, 128, message width (ID, DLC, DW1, DW2).

Ports:
- i_sys_clk  in  1  system clock
- i_reset_n  in  1  asynchronous active-low reset
- i_cen  in  1  core enable (SRR CEN)
- i_bsoff  in  1  bus-off status
- i_hpb_full  in  1  HPB holds a message
- i_hpb_data  in  MSG_W  HPB contents, stable while full
- o_hpb_r_en  out  1  one-cycle HPB pop
- i_tx_empty  in  1  TX FIFO empty
- i_tx_fifo_data  in  MSG_W  FIFO head (first-word fall-through), stable until pop
- o_tx_r_en  out  1  one-cycle FIFO pop
- o_msg_data  out  MSG_W  held message to the transmitter
- o_msg_valid  out  1  transmit request
- i_msg_ready  in  1  transmitter accepts request
- i_txok  in  1  frame sent pulse
- i_arblst  in  1  arbitration lost pulse
- i_error  in  1  transmit error pulse
- o_src_hpb  out  1  held message came from the HPB
- o_retry_cnt  out  4  error retries of the current message
- o_tx_done  out  1  one-cycle pulse on success
- o_drop  out  1  one-cycle pulse when the retry limit is hit
- o_abort  out  1  one-cycle pulse on bus-off or disable abort
- o_busy  out  1  state != IDLE

Behaviour:
- Reset (async, i_reset_n=0): state IDLE; all outputs 0; o_msg_data=0; retry count 0.
- States: IDLE, LOAD, REQ, WAIT.
- IDLE:
  - If i_cen=1 and i_bsoff=0: i_hpb_full=1 -> LOAD with source HPB; else i_tx_empty=0 -> LOAD with source FIFO; else stay.
  - HPB wins if both are available in the same cycle.
- LOAD (exactly 1 cycle):
  - Assert o_hpb_r_en or o_tx_r_en per the chosen source.
  - Latch the source data into o_msg_data at the cycle's end.
  - Set o_src_hpb, clear the retry count, go to REQ.
- REQ:
  - o_msg_valid=1 until the cycle in which i_msg_ready=1, then WAIT.
  - i_txok, i_arblst and i_error are ignored in REQ.
- WAIT: o_msg_valid=0. Priority when pulses coincide: i_txok > i_error > i_arblst.
  - i_txok: o_tx_done pulse, go to IDLE.
  - i_arblst: go to REQ; the retry count is unchanged and arbitration loss is never limited.
  - i_error: if MAX_RETRY!=0 and retry_cnt+1 >= MAX_RETRY, pulse o_drop and go to IDLE. Otherwise increment retry_cnt (saturating at 15) and go to REQ.
- Abort: in LOAD, REQ or WAIT, if i_cen=0 or i_bsoff=1:
  - Go to IDLE next cycle, pulse o_abort, deassert o_msg_valid.
  - The held message is discarded; the source was already popped.
  - If abort occurs in LOAD, the pop still completes in that cycle.
- Preemption: a retried message is never preempted. An HPB that fills during REQ or WAIT is served at the next IDLE.
- Latency: from IDLE with a source available, o_*_r_en rises 1 cycle later and o_msg_valid 2 cycles later.
- Back-to-back: IDLE is visited for at least 1 cycle between messages.
- Pop outputs are decoded from registered state only; no input-to-pop combinational path.
- o_msg_data holds its value in IDLE until the next LOAD.

Decomposition:
- can_pkg:
  - typedef enum logic [1:0] tx_sched_state_t {IDLE, LOAD, REQ, WAIT}
  - localparam CAN_MSG_W=128
  - typedef logic [CAN_MSG_W-1:0] can_msg_t
- The retry counter is a natural sub-module: can_tx_retry_ctr (clear, increment, saturate, limit-hit flag).
- Everything else lives in one file.

Test Plan:
- HPB full and FIFO non-empty together at IDLE -> o_hpb_r_en pulse at t+1, o_msg_valid at t+2 with HPB data, o_src_hpb=1. After i_txok, o_tx_done pulse and the FIFO message follows with o_tx_r_en.
- FIFO message 128'hA5..; i_msg_ready held low 5 cycles -> o_msg_valid stays high 5 cycles, then WAIT; i_txok -> o_tx_done=1 for 1 cycle, o_busy=0.
- MAX_RETRY=3; three i_error pulses -> two re-requests with retry_cnt 1 then 2, o_drop on the third, no o_tx_done.
- Ten consecutive i_arblst pulses -> ten re-requests, retry_cnt stays 0, the final i_txok completes.
- i_bsoff=1 during WAIT -> o_abort pulse, IDLE next cycle, no pop while bus-off persists. i_txok and i_error asserted in the same WAIT cycle -> o_tx_done only.
- i_reset_n low mid-REQ -> all outputs 0 immediately. Release with HPB full -> normal LOAD sequence resumes.
